// File: rtl/alu_seq.sv
// Sequential ALU for the execute stage: registered result and NZCV flags,
// start/done handshake, and an iterative shift-add multiplier.
module alu_seq #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic             set_flags,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_RSB = 4'b0010;
  localparam logic [3:0] OP_AND = 4'b0011;
  localparam logic [3:0] OP_NOT = 4'b0100;
  localparam logic [3:0] OP_TST = 4'b0101;
  localparam logic [3:0] OP_CMP = 4'b0110;
  localparam logic [3:0] OP_MOV = 4'b0111;
  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam logic [3:0] OP_LSL = 4'b1001;
  localparam logic [3:0] OP_LSR = 4'b1010;
  localparam logic [3:0] OP_ASR = 4'b1011;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_EOR = 4'b1101;

  typedef enum logic [0:0] {S_IDLE, S_MULT} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [3:0]         flags_q, flags_d;
  logic               done_q, done_d;
  logic [SHW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic               sf_q, sf_d;

  // Flag helpers: flags are packed {V,N,C,Z}.
  function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
    return (sa == sb) && (sr != sa);
  endfunction

  function automatic logic sub_ovf(input logic sm, input logic ss, input logic sr);
    return (sm != ss) && (sr != sm);
  endfunction

  function automatic logic [3:0] mk_flags(input logic v, input logic c,
                                          input logic [WIDTH-1:0] r);
    return {v, r[WIDTH-1], c, (r == '0)};
  endfunction

  logic [WIDTH:0]        sum_ext, sub_ab, sub_ba, shl_ext, shr_ext;
  logic signed [WIDTH:0] asr_in, asr_ext;
  logic [SHW-1:0]        amt;
  logic [WIDTH-1:0]      alu_res;
  logic [3:0]            alu_flags;
  logic                  wr_res, wr_flags;
  logic [WIDTH-1:0]      acc_next;

  assign amt = b[SHW-1:0];

  always_comb begin
    sum_ext   = {1'b0, a} + {1'b0, b};
    sub_ab    = {1'b0, a} - {1'b0, b};
    sub_ba    = {1'b0, b} - {1'b0, a};
    shl_ext   = {1'b0, a} << amt;
    shr_ext   = {a, 1'b0} >> amt;
    asr_in    = {a, 1'b0};
    asr_ext   = asr_in >>> amt;
    alu_res   = result_q;
    alu_flags = flags_q;
    wr_res    = 1'b1;
    wr_flags  = set_flags;
    unique case (op)
      OP_ADD: begin
        alu_res   = sum_ext[WIDTH-1:0];
        alu_flags = mk_flags(add_ovf(a[WIDTH-1], b[WIDTH-1], sum_ext[WIDTH-1]),
                             sum_ext[WIDTH], sum_ext[WIDTH-1:0]);
      end
      OP_SUB, OP_CMP: begin
        // C is NOT borrow, so it is the inverted bit above the result.
        alu_res   = sub_ab[WIDTH-1:0];
        alu_flags = mk_flags(sub_ovf(a[WIDTH-1], b[WIDTH-1], sub_ab[WIDTH-1]),
                             ~sub_ab[WIDTH], sub_ab[WIDTH-1:0]);
        if (op == OP_CMP) begin
          wr_res   = 1'b0;
          wr_flags = 1'b1;
        end
      end
      OP_RSB: begin
        alu_res   = sub_ba[WIDTH-1:0];
        alu_flags = mk_flags(sub_ovf(b[WIDTH-1], a[WIDTH-1], sub_ba[WIDTH-1]),
                             ~sub_ba[WIDTH], sub_ba[WIDTH-1:0]);
      end
      OP_AND, OP_TST: begin
        alu_res   = a & b;
        alu_flags = mk_flags(flags_q[3], flags_q[1], a & b);
        if (op == OP_TST) begin
          wr_res   = 1'b0;
          wr_flags = 1'b1;
        end
      end
      OP_NOT: begin
        alu_res   = ~b;
        alu_flags = mk_flags(flags_q[3], flags_q[1], ~b);
      end
      OP_MOV: begin
        alu_res   = b;
        alu_flags = mk_flags(flags_q[3], flags_q[1], b);
      end
      OP_ORR: begin
        alu_res   = a | b;
        alu_flags = mk_flags(flags_q[3], flags_q[1], a | b);
      end
      OP_EOR: begin
        alu_res   = a ^ b;
        alu_flags = mk_flags(flags_q[3], flags_q[1], a ^ b);
      end
      OP_LSL: begin
        alu_res   = shl_ext[WIDTH-1:0];
        alu_flags = mk_flags(flags_q[3], (amt == '0) ? flags_q[1] : shl_ext[WIDTH],
                             shl_ext[WIDTH-1:0]);
      end
      OP_LSR: begin
        alu_res   = shr_ext[WIDTH:1];
        alu_flags = mk_flags(flags_q[3], (amt == '0) ? flags_q[1] : shr_ext[0],
                             shr_ext[WIDTH:1]);
      end
      OP_ASR: begin
        alu_res   = asr_ext[WIDTH:1];
        alu_flags = mk_flags(flags_q[3], (amt == '0) ? flags_q[1] : asr_ext[0],
                             asr_ext[WIDTH:1]);
      end
      default: begin
        // Reserved codes (and MUL, handled by the FSM) leave state untouched.
        wr_res   = 1'b0;
        wr_flags = 1'b0;
      end
    endcase
  end

  assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    flags_d  = flags_q;
    done_d   = 1'b0;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    sf_d     = sf_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (op == OP_MUL) begin
            state_d  = S_MULT;
            mcand_d  = a;
            mplier_d = b;
            sf_d     = set_flags;
            acc_d    = '0;
            cnt_d    = '0;
          end else begin
            done_d = 1'b1;
            if (wr_res)   result_d = alu_res;
            if (wr_flags) flags_d  = alu_flags;
          end
        end
      end
      S_MULT: begin
        acc_d    = acc_next;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == SHW'(WIDTH - 1)) begin
          state_d  = S_IDLE;
          result_d = acc_next;
          done_d   = 1'b1;
          cnt_d    = '0;
          if (sf_q) flags_d = mk_flags(flags_q[3], flags_q[1], acc_next);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
    end
  end

  // Multiplier datapath needs no reset: it is loaded on every MUL acceptance.
  always_ff @(posedge clk) begin
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
    acc_q    <= acc_d;
    sf_q     <= sf_d;
  end

  assign busy   = (state_q == S_MULT);
  assign done   = done_q;
  assign result = result_q;
  assign flags  = flags_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq with hand-computed expected results and flags.
module tb_alu_seq;

  localparam logic [3:0] ADD = 4'b0000, SUB = 4'b0001, RSB = 4'b0010, ANDO = 4'b0011;
  localparam logic [3:0] CMP = 4'b0110, MOV = 4'b0111, MUL = 4'b1000, LSL = 4'b1001;
  localparam logic [3:0] LSR = 4'b1010, ASR = 4'b1011, RSV = 4'b1110;

  logic        clk = 1'b0;
  logic        rst_n, start, set_flags, busy, done;
  logic [3:0]  op, flags;
  logic [31:0] a, b, result;

  int n_vec = 0;
  int n_err = 0;

  alu_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .set_flags(set_flags),
    .a(a), .b(b), .busy(busy), .done(done), .result(result), .flags(flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] o, input logic [31:0] va, input logic [31:0] vb,
                       input logic sf);
    op = o; a = va; b = vb; set_flags = sf; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  int busy_cycles;
  int guard;

  initial begin
    rst_n = 1'b0; start = 1'b0; op = ADD; a = '0; b = '0; set_flags = 1'b0;
    tick(); tick();
    chk("rst_result", result, 32'h0);
    chk("rst_flags", {28'h0, flags}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    rst_n = 1'b1;
    tick();

    issue(ADD, 32'h7FFF_FFFF, 32'h1, 1'b1);
    chk("add_res", result, 32'h8000_0000);
    chk("add_flags", {28'h0, flags}, 32'hC);
    chk("add_done", {31'h0, done}, 32'h1);
    tick();
    chk("idle_done", {31'h0, done}, 32'h0);

    issue(ADD, 32'h1, 32'h1, 1'b0);
    chk("add_nf_res", result, 32'h2);
    chk("add_nf_flags", {28'h0, flags}, 32'hC);

    issue(SUB, 32'd5, 32'd5, 1'b1);
    chk("sub_res", result, 32'h0);
    chk("sub_flags", {28'h0, flags}, 32'h3);

    issue(CMP, 32'd3, 32'd5, 1'b0);
    chk("cmp_res", result, 32'h0);
    chk("cmp_flags", {28'h0, flags}, 32'h4);

    issue(RSB, 32'd2, 32'd7, 1'b1);
    chk("rsb_res", result, 32'd5);
    chk("rsb_flags", {28'h0, flags}, 32'h2);

    issue(CMP, 32'd3, 32'd5, 1'b0);
    issue(LSR, 32'h3, 32'd1, 1'b1);
    chk("lsr_res", result, 32'h1);
    chk("lsr_flags", {28'h0, flags}, 32'h2);

    issue(ASR, 32'h8000_0000, 32'd31, 1'b1);
    chk("asr_res", result, 32'hFFFF_FFFF);
    chk("asr_flags", {28'h0, flags}, 32'h4);

    issue(LSL, 32'h8000_0001, 32'd1, 1'b1);
    chk("lsl_res", result, 32'h2);
    chk("lsl_flags", {28'h0, flags}, 32'h2);

    issue(SUB, 32'd5, 32'd5, 1'b1);
    issue(LSL, 32'h8000_0001, 32'd0, 1'b1);
    chk("lsl0_res", result, 32'h8000_0001);
    chk("lsl0_flags", {28'h0, flags}, 32'h6);

    // MUL with operand disturbance and an ignored start while busy
    issue(SUB, 32'd5, 32'd5, 1'b1);
    issue(MUL, 32'h0000_FFFF, 32'h0001_0001, 1'b1);
    chk("mul_busy0", {31'h0, busy}, 32'h1);
    chk("mul_done0", {31'h0, done}, 32'h0);
    busy_cycles = 0;
    guard = 0;
    while (busy && guard < 100) begin
      busy_cycles++;
      guard++;
      if (done) chk("mul_done_busy", {31'h0, done}, 32'h0);
      if (busy_cycles == 3) begin a = 32'h0; b = 32'h0; end
      if (busy_cycles == 5) begin op = ADD; a = 32'd9; b = 32'd9; start = 1'b1; end
      if (busy_cycles == 6) start = 1'b0;
      tick();
    end
    chk("mul_busy_len", busy_cycles, 32'd32);
    chk("mul_res", result, 32'hFFFF_FFFF);
    chk("mul_flags", {28'h0, flags}, 32'h6);
    chk("mul_done", {31'h0, done}, 32'h1);
    tick();
    chk("mul_done_pulse", {31'h0, done}, 32'h0);
    chk("mul_res_hold", result, 32'hFFFF_FFFF);

    // Back-to-back single-cycle ops, including a reserved code
    op = ADD; a = 32'hFFFF_FFFF; b = 32'h2; set_flags = 1'b1; start = 1'b1;
    tick();
    chk("b2b_add_res", result, 32'h1);
    chk("b2b_add_flags", {28'h0, flags}, 32'h2);
    chk("b2b_add_done", {31'h0, done}, 32'h1);
    op = ANDO; a = 32'hF0; b = 32'h3C;
    tick();
    chk("b2b_and_res", result, 32'h30);
    chk("b2b_and_done", {31'h0, done}, 32'h1);
    op = RSV; a = 32'h0; b = 32'h0;
    tick();
    chk("b2b_rsv_res", result, 32'h30);
    chk("b2b_rsv_flags", {28'h0, flags}, 32'h2);
    chk("b2b_rsv_done", {31'h0, done}, 32'h1);
    op = MOV; b = 32'h0;
    tick();
    start = 1'b0;
    chk("b2b_mov_res", result, 32'h0);
    chk("b2b_mov_flags", {28'h0, flags}, 32'h3);
    chk("b2b_mov_done", {31'h0, done}, 32'h1);
    tick();
    chk("b2b_end_done", {31'h0, done}, 32'h0);

    // Reset in the middle of a multiply aborts it without a done pulse
    issue(ADD, 32'h7FFF_FFFF, 32'h1, 1'b1);
    issue(MUL, 32'h3, 32'h5, 1'b1);
    repeat (9) tick();
    chk("abort_busy_pre", {31'h0, busy}, 32'h1);
    rst_n = 1'b0;
    tick();
    chk("abort_busy", {31'h0, busy}, 32'h0);
    chk("abort_done", {31'h0, done}, 32'h0);
    tick();
    rst_n = 1'b1;
    chk("abort_result", result, 32'h0);
    chk("abort_flags", {28'h0, flags}, 32'h0);
    repeat (40) begin
      tick();
      if (done || busy) chk("abort_quiet", {30'h0, done, busy}, 32'h0);
    end
    issue(RSB, 32'd2, 32'd7, 1'b1);
    chk("post_rst_res", result, 32'd5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
